// File: rtl/sdram_arbit.sv
// sdram_arbit: command arbiter between the SDRAM sub-controllers and the device pins.
// Holds the bus for the init sequence, then grants one requester at a time with fixed
// priority refresh > write > read, returning to an idle ARBIT state between grants.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   init_cmd/addr, flag_init_end    init block command bus and done flag
//   aref_req/cmd/addr/flag_aref_end refresh block request, bus and end pulse; aref_en grant
//   wr_req/cmd/addr/bank/data       write block request, bus and data; flag_wr_end, wr_en
//   rd_req/cmd/addr/bank            read block request and bus; flag_rd_end, rd_en
//   rd_data                         sdram_dq passed straight through
//   sdram_*                         device pins; sdram_dq driven only while writing
module sdram_arbit #(
   parameter int unsigned DQ_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      init_cmd,
   input  logic [12:0]     init_addr,
   input  logic            flag_init_end,
   input  logic            aref_req,
   input  logic [3:0]      aref_cmd,
   input  logic [12:0]     aref_addr,
   input  logic            flag_aref_end,
   output logic            aref_en,
   input  logic            wr_req,
   input  logic [3:0]      wr_cmd,
   input  logic [12:0]     wr_addr,
   input  logic [1:0]      wr_bank,
   input  logic [DQ_W-1:0] wr_data,
   input  logic            flag_wr_end,
   output logic            wr_en,
   input  logic            rd_req,
   input  logic [3:0]      rd_cmd,
   input  logic [12:0]     rd_addr,
   input  logic [1:0]      rd_bank,
   input  logic            flag_rd_end,
   output logic            rd_en,
   output logic [DQ_W-1:0] rd_data,
   output logic            sdram_cke,
   output logic            sdram_cs_n,
   output logic            sdram_ras_n,
   output logic            sdram_cas_n,
   output logic            sdram_we_n,
   output logic [1:0]      sdram_bank,
   output logic [12:0]     sdram_addr,
   inout  wire  [DQ_W-1:0] sdram_dq
);

   localparam logic [3:0] CmdNop = 4'b0111;

   typedef enum logic [2:0] {
      StInit,
      StArbit,
      StAref,
      StWrite,
      StRead
   } state_t;

   state_t     state;
   logic [3:0] cmd;

   // Only the granted block's end flag is examined, so stray flags are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= StInit;
      end else begin
         unique case (state)
            StInit:  if (flag_init_end) state <= StArbit;
            StArbit: begin
               if (aref_req)    state <= StAref;
               else if (wr_req) state <= StWrite;
               else if (rd_req) state <= StRead;
            end
            StAref:  if (flag_aref_end) state <= StArbit;
            StWrite: if (flag_wr_end)   state <= StArbit;
            StRead:  if (flag_rd_end)   state <= StArbit;
            default: state <= StInit;
         endcase
      end
   end

   // Grants and bus are pure decodes of state so a reset drops them without a clock.
   always_comb begin
      aref_en    = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      cmd        = CmdNop;
      sdram_addr = 13'd0;
      sdram_bank = 2'b00;
      unique case (state)
         StInit: begin
            cmd        = init_cmd;
            sdram_addr = init_addr;
         end
         StAref: begin
            aref_en    = 1'b1;
            cmd        = aref_cmd;
            sdram_addr = aref_addr;
         end
         StWrite: begin
            wr_en      = 1'b1;
            cmd        = wr_cmd;
            sdram_addr = wr_addr;
            sdram_bank = wr_bank;
         end
         StRead: begin
            rd_en      = 1'b1;
            cmd        = rd_cmd;
            sdram_addr = rd_addr;
            sdram_bank = rd_bank;
         end
         default: ;
      endcase
   end

   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
   assign sdram_cke = 1'b1;
   assign sdram_dq  = (state == StWrite) ? wr_data : {DQ_W{1'bz}};
   assign rd_data   = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
module tb_sdram_arbit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  init_cmd = 4'b0111;
   logic [12:0] init_addr = 13'd0;
   logic        flag_init_end = 1'b0;
   logic        aref_req = 1'b0;
   logic [3:0]  aref_cmd = 4'b0111;
   logic [12:0] aref_addr = 13'd0;
   logic        flag_aref_end = 1'b0;
   logic        aref_en;
   logic        wr_req = 1'b0;
   logic [3:0]  wr_cmd = 4'b0111;
   logic [12:0] wr_addr = 13'd0;
   logic [1:0]  wr_bank = 2'b00;
   logic [15:0] wr_data = 16'h0000;
   logic        flag_wr_end = 1'b0;
   logic        wr_en;
   logic        rd_req = 1'b0;
   logic [3:0]  rd_cmd = 4'b0111;
   logic [12:0] rd_addr = 13'd0;
   logic [1:0]  rd_bank = 2'b00;
   logic        flag_rd_end = 1'b0;
   logic        rd_en;
   logic [15:0] rd_data;
   logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0]  sdram_bank;
   logic [12:0] sdram_addr;
   wire  [15:0] sdram_dq;

   // Bench-side bus keeper: drives a known pattern whenever the DUT should be off the bus.
   logic        tb_drv_en = 1'b1;
   logic [15:0] tb_drv = 16'h3C3C;
   assign sdram_dq = tb_drv_en ? tb_drv : 16'hzzzz;

   wire [3:0] cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
   wire [2:0] gnt = {aref_en, wr_en, rd_en};

   int total = 0;
   int bad = 0;
   int aref_cycles;

   sdram_arbit #(.DQ_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .init_cmd(init_cmd), .init_addr(init_addr), .flag_init_end(flag_init_end),
      .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
      .flag_aref_end(flag_aref_end), .aref_en(aref_en),
      .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
      .wr_data(wr_data), .flag_wr_end(flag_wr_end), .wr_en(wr_en),
      .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
      .flag_rd_end(flag_rd_end), .rd_en(rd_en), .rd_data(rd_data),
      .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
      .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_bank(sdram_bank),
      .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0]  init_cmds [4];
      logic [12:0] init_addrs [4];
      init_cmds  = '{4'b0010, 4'b0001, 4'b0000, 4'b0111};
      init_addrs = '{13'h0400, 13'h0000, 13'h0032, 13'h0000};

      // Reset state.
      init_cmd  = 4'b0010;
      init_addr = 13'h0400;
      #12;
      chk("rst_gnt", {29'd0, gnt}, 32'd0);
      chk("rst_cmd", {28'd0, cmd}, 32'h2);
      chk("rst_addr", {19'd0, sdram_addr}, 32'h400);
      chk("rst_bank", {30'd0, sdram_bank}, 32'd0);
      chk("rst_cke", {31'd0, sdram_cke}, 32'd1);
      chk("rst_dq_off", {16'd0, rd_data}, 32'h3C3C);
      rst_n = 1'b1;

      // Init phase: bus follows the init block for cycles 0-20.
      for (int i = 0; i < 20; i++) begin
         init_cmd  = init_cmds[i % 4];
         init_addr = init_addrs[i % 4];
         tick();
         if (i % 5 == 0) begin
            chk("init_cmd", {28'd0, cmd}, {28'd0, init_cmds[i % 4]});
            chk("init_addr", {19'd0, sdram_addr}, {19'd0, init_addrs[i % 4]});
         end
      end
      init_cmd  = 4'b0001;
      init_addr = 13'h1ABC;
      flag_init_end = 1'b1;
      tick();
      flag_init_end = 1'b0;
      chk("arbit_cmd", {28'd0, cmd}, 32'h7);
      chk("arbit_addr", {19'd0, sdram_addr}, 32'd0);
      chk("arbit_gnt", {29'd0, gnt}, 32'd0);
      tick();
      chk("arbit_idle", {29'd0, gnt}, 32'd0);

      // Single refresh: model ends the grant on its 7th cycle.
      aref_cmd  = 4'b0001;
      aref_addr = 13'h0400;
      aref_req  = 1'b1;
      aref_cycles = 0;
      tick();
      for (int i = 1; i <= 7; i++) begin
         if (aref_en) aref_cycles++;
         if (i == 1) begin
            chk("aref_cmd", {28'd0, cmd}, 32'h1);
            chk("aref_addr", {19'd0, sdram_addr}, 32'h400);
            aref_req = 1'b0;
         end
         if (i == 7) flag_aref_end = 1'b1;
         tick();
      end
      flag_aref_end = 1'b0;
      chk("aref_len", aref_cycles, 32'd7);
      chk("aref_done_gnt", {29'd0, gnt}, 32'd0);
      chk("aref_done_cmd", {28'd0, cmd}, 32'h7);

      // Simultaneous requests: AREF, then WRITE, then READ with one ARBIT between.
      aref_req = 1'b1;
      wr_req   = 1'b1;
      rd_req   = 1'b1;
      tick();
      chk("pri_aref", {29'd0, gnt}, 32'b100);
      aref_req = 1'b0;
      flag_aref_end = 1'b1;
      tick();
      flag_aref_end = 1'b0;
      chk("pri_gap1", {29'd0, gnt}, 32'b000);
      tick();
      chk("pri_wr", {29'd0, gnt}, 32'b010);
      wr_req = 1'b0;
      flag_wr_end = 1'b1;
      tick();
      flag_wr_end = 1'b0;
      chk("pri_gap2", {29'd0, gnt}, 32'b000);
      tick();
      chk("pri_rd", {29'd0, gnt}, 32'b001);
      rd_req = 1'b0;
      flag_rd_end = 1'b1;
      tick();
      flag_rd_end = 1'b0;
      chk("pri_gap3", {29'd0, gnt}, 32'b000);
      tick();
      chk("pri_idle", {29'd0, gnt}, 32'b000);

      // Write with data, refresh arriving mid-write must wait.
      wr_cmd  = 4'b0100;
      wr_addr = 13'h0123;
      wr_bank = 2'b10;
      wr_data = 16'hA5A5;
      wr_req  = 1'b1;
      tb_drv_en = 1'b0;
      tick();
      chk("wr_gnt", {29'd0, gnt}, 32'b010);
      chk("wr_dq", {16'd0, rd_data}, 32'hA5A5);
      chk("wr_bank", {30'd0, sdram_bank}, 32'h2);
      chk("wr_cmd", {28'd0, cmd}, 32'h4);
      chk("wr_addr", {19'd0, sdram_addr}, 32'h123);
      aref_req = 1'b1;
      tick();
      chk("nopreempt1", {29'd0, gnt}, 32'b010);
      tick();
      chk("nopreempt2", {29'd0, gnt}, 32'b010);
      flag_wr_end = 1'b1;
      tick();
      tb_drv_en = 1'b1;
      flag_wr_end = 1'b0;
      wr_req = 1'b0;
      #1;
      chk("wr_end_gnt", {29'd0, gnt}, 32'b000);
      chk("wr_end_dq_off", {16'd0, rd_data}, 32'h3C3C);
      chk("wr_end_bank", {30'd0, sdram_bank}, 32'd0);
      tick();
      chk("aref_after_wr", {29'd0, gnt}, 32'b100);
      chk("aref_dq_off", {16'd0, rd_data}, 32'h3C3C);
      aref_req = 1'b0;
      flag_aref_end = 1'b1;
      tick();
      flag_aref_end = 1'b0;
      chk("aref2_done", {29'd0, gnt}, 32'b000);

      // Read with stray end flags, then asynchronous reset mid-read.
      rd_cmd  = 4'b0101;
      rd_addr = 13'h0055;
      rd_bank = 2'b01;
      rd_req  = 1'b1;
      tick();
      chk("rd_gnt", {29'd0, gnt}, 32'b001);
      chk("rd_bank", {30'd0, sdram_bank}, 32'h1);
      chk("rd_addr", {19'd0, sdram_addr}, 32'h55);
      chk("rd_cmd", {28'd0, cmd}, 32'h5);
      flag_wr_end = 1'b1;
      flag_aref_end = 1'b1;
      tick();
      chk("stray1", {29'd0, gnt}, 32'b001);
      flag_aref_end = 1'b0;
      tick();
      chk("stray2", {29'd0, gnt}, 32'b001);
      flag_wr_end = 1'b0;
      init_cmd  = 4'b0010;
      init_addr = 13'h0400;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_gnt", {29'd0, gnt}, 32'd0);
      chk("async_rst_cmd", {28'd0, cmd}, 32'h2);
      chk("async_rst_bank", {30'd0, sdram_bank}, 32'd0);
      #10;
      rst_n = 1'b1;
      tick();
      chk("post_rst_init", {29'd0, gnt}, 32'd0);
      chk("post_rst_addr", {19'd0, sdram_addr}, 32'h400);
      rd_req = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Grants are mutually exclusive at every sample point.
   always @(negedge clk) begin
      if (rst_n && ((gnt & (gnt - 3'd1)) != 3'd0)) begin
         chk("onehot", {29'd0, gnt}, 32'd0);
      end
   end

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Command arbiter between the SDRAM sub-controllers (init, auto-refresh, write, read) and the SDRAM pins. It holds the bus for the init sequence, then grants one requester at a time with fixed priority refresh > write > read. It muxes the winner's command, address and bank onto the device bus and drives the data bus during writes. It sits directly downstream of the auto-refresh block: it consumes `aref_req`, `aref_cmd`, `aref_addr` and `flag_aref_end`, and returns `aref_en`.

## Interface
Parameters:
- `DQ_W`, 16: SDRAM data width.

Command encoding on all `*_cmd` ports is {cs_n, ras_n, cas_n, we_n}: NOP = 4'b0111, AREF = 4'b0001, PALL = 4'b0010.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `init_cmd`  in  4  init block command.
- `init_addr`  in  13  init block address.
- `flag_init_end`  in  1  init sequence done; single-cycle pulse or level.
- `aref_req`  in  1  refresh request; held until `aref_en` is seen.
- `aref_cmd`  in  4  refresh block command.
- `aref_addr`  in  13  refresh block address.
- `flag_aref_end`  in  1  one-cycle end-of-refresh pulse.
- `aref_en`  out  1  refresh grant.
- `wr_req`  in  1  write request.
- `wr_cmd`  in  4  write block command.
- `wr_addr`  in  13  write block address.
- `wr_bank`  in  2  write block bank.
- `wr_data`  in  DQ_W  write data.
- `flag_wr_end`  in  1  one-cycle end-of-write pulse.
- `wr_en`  out  1  write grant.
- `rd_req`  in  1  read request.
- `rd_cmd`  in  4  read block command.
- `rd_addr`  in  13  read block address.
- `rd_bank`  in  2  read block bank.
- `flag_rd_end`  in  1  one-cycle end-of-read pulse.
- `rd_en`  out  1  read grant.
- `rd_data`  out  DQ_W  `sdram_dq` passed through unregistered.
- `sdram_cke`  out  1  constant 1.
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n`  out  1 each  bits [3:0] of the selected command.
- `sdram_bank`  out  2  selected bank.
- `sdram_addr`  out  13  selected address.
- `sdram_dq`  inout  DQ_W  data bus.

## Operation
State register is 5 states, one-hot or binary: INIT, ARBIT, AREF, WRITE, READ. Reset value is INIT.

Transitions:
- INIT -> ARBIT when `flag_init_end` = 1.
- ARBIT -> AREF if `aref_req`; else WRITE if `wr_req`; else READ if `rd_req`; else stay in ARBIT.
- AREF -> ARBIT on `flag_aref_end`.
- WRITE -> ARBIT on `flag_wr_end`.
- READ -> ARBIT on `flag_rd_end`.

Grants:
- Grants are combinational decodes of state: `aref_en` = (state == AREF), `wr_en` = (state == WRITE), `rd_en` = (state == READ).
- At most one grant is high in any cycle.

Bus mux (combinational on state):

| State | Command | Address | Bank |
|---|---|---|---|
| INIT | `init_cmd` | `init_addr` | 2'b00 |
| AREF | `aref_cmd` | `aref_addr` | 2'b00 |
| WRITE | `wr_cmd` | `wr_addr` | `wr_bank` |
| READ | `rd_cmd` | `rd_addr` | `rd_bank` |
| ARBIT | NOP | 13'd0 | 2'b00 |

Data bus:
- `sdram_dq` = `wr_data` when state == WRITE; high-Z otherwise.
- `rd_data` = `sdram_dq` at all times.

Boundary rules:
- End flags whose block is not currently granted are ignored, e.g. `flag_wr_end` while in AREF.
- Requests arriving mid-grant are not lost: the requesting blocks hold their level and are arbitrated at the next ARBIT.
- Simultaneous `aref_req`, `wr_req` and `rd_req`: AREF wins, then write, then read on subsequent arbitrations.
- No preemption. A pending refresh waits until the active write or read ends. Bounding burst length is the write and read blocks' job.
- `rst_n` low mid-operation: state returns to INIT immediately and all grants drop asynchronously.

## Timing
- ARBIT lasts at least 1 cycle between grants. An end flag at edge N gives ARBIT in cycle N+1; the next grant is visible at cycle N+2.
- The grant rises the cycle after the request is seen in ARBIT. It falls the cycle after the end flag.
- Refresh block timing: `aref_en` is high for exactly 7 cycles per refresh. `aref_req` clears one cycle after `aref_en` rises.
- Reset values:
  - `aref_en`, `wr_en`, `rd_en` = 0.
  - Bus = `init_cmd`/`init_addr` (NOP/0 from a reset init block); `sdram_bank` = 0.
  - `sdram_cke` = 1; `sdram_dq` = high-Z.
- No output is registered in this block. Command outputs carry the registered outputs of the source blocks through one mux level.

## Test plan
- Reset, then `flag_init_end` pulse at cycle 20 -> bus follows `init_cmd` for cycles 0-20; ARBIT from cycle 21 with `sdram_cmd` = 4'b0111 and `sdram_addr` = 0.
- `aref_req` = 1 in ARBIT, refresh model asserts `flag_aref_end` 7 cycles into the grant -> `aref_en` high exactly 7 cycles; AREF (4'b0001) and addr 13'h400 seen on the bus; return to ARBIT.
- `aref_req`, `wr_req` and `rd_req` asserted in the same cycle -> order AREF, WRITE, READ, with exactly one ARBIT cycle between grants and never two grants high at once.
- `aref_req` rises mid-WRITE -> WRITE continues until `flag_wr_end`; AREF is granted 2 cycles later.
- WRITE with `wr_data` = 16'hA5A5 and `wr_bank` = 2'b10 -> `sdram_dq` = A5A5 and `sdram_bank` = 2 only while `wr_en` = 1; high-Z otherwise.
- `rst_n` pulsed low mid-READ with stray `flag_wr_end` pulses injected -> stray flags cause no transition; reset forces INIT with all grants 0 immediately.
